// File: rtl/video_fill.sv
// Rectangle fill engine for the 256x240 4-bpp framebuffer: clips the requested
// rectangle to the screen and streams one write per pixel over a WE/WACK port.
module video_fill #(
  parameter int unsigned SCR_W = 256,
  parameter int unsigned SCR_H = 240,
  parameter int unsigned AW    = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [7:0]    X0,
  input  logic [7:0]    Y0,
  input  logic [8:0]    W,
  input  logic [7:0]    H,
  input  logic [3:0]    COLOR,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] WA,
  output logic [3:0]    WD,
  output logic          WE,
  input  logic          WACK
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [8:0] SCR_W9 = 9'(SCR_W);
  localparam logic [8:0] SCR_H9 = 9'(SCR_H);

  state_t     state;
  logic [7:0] x0_q, y0_q, h_q;
  logic [8:0] w_q;
  logic [3:0] color_q;
  logic [7:0] x, y;
  logic [8:0] wc_q;
  logic [8:0] col_left;
  logic [7:0] row_left;
  logic       we, done;

  logic [8:0] room_x, room_y;
  logic [8:0] wc;
  logic [7:0] hc;

  // Clipped extents, evaluated from the values latched at START.
  always_comb begin
    room_x = SCR_W9 - {1'b0, x0_q};
    room_y = '0;
    wc     = (w_q < room_x) ? w_q : room_x;
    hc     = '0;
    if ({1'b0, y0_q} < SCR_H9) begin
      room_y = SCR_H9 - {1'b0, y0_q};
      hc     = ({1'b0, h_q} < room_y) ? h_q : room_y[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x        <= '0;
      y        <= '0;
      wc_q     <= '0;
      col_left <= '0;
      row_left <= '0;
      we       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            x0_q    <= X0;
            y0_q    <= Y0;
            w_q     <= W;
            h_q     <= H;
            color_q <= COLOR;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (ABORT) begin
            state <= IDLE;
          end else begin
            x        <= x0_q;
            y        <= y0_q;
            wc_q     <= wc;
            col_left <= wc;
            row_left <= hc;
            if (wc == '0 || hc == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= WRITE;
              we    <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (we && WACK) begin
            if (col_left == 9'd1) begin
              if (row_left == 8'd1) begin
                state <= FIN;
                we    <= 1'b0;
                done  <= 1'b1;
              end else begin
                x        <= x0_q;
                y        <= y + 8'd1;
                col_left <= wc_q;
                row_left <= row_left - 8'd1;
              end
            end else begin
              x        <= x + 8'd1;
              col_left <= col_left - 9'd1;
            end
          end
          // Abort overrides even a final acknowledge: no DONE is reported.
          if (ABORT) begin
            state <= IDLE;
            we    <= 1'b0;
            done  <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = done;
  assign WE   = we;
  assign WD   = color_q;
  assign WA   = AW'({y, x});

endmodule

// File: tb/tb_video_fill.sv
// Directed bench for video_fill: hand-computed write sequences checked cycle by cycle.
module tb_video_fill;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        WACK = 1'b1;
  logic [7:0]  X0 = '0, Y0 = '0, H = '0;
  logic [8:0]  W = '0;
  logic [3:0]  COLOR = '0;
  logic        BUSY, DONE, WE;
  logic [15:0] WA;
  logic [3:0]  WD;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  video_fill #(.SCR_W(256), .SCR_H(240), .AW(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .X0(X0), .Y0(Y0), .W(W), .H(H), .COLOR(COLOR),
    .BUSY(BUSY), .DONE(DONE), .WA(WA), .WD(WD), .WE(WE), .WACK(WACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse START for one edge, then scramble inputs to prove they were latched.
  task automatic launch(input logic [7:0] x0, input logic [7:0] y0,
                        input logic [8:0] w, input logic [7:0] h, input logic [3:0] col);
    @(negedge CLK);
    X0 = x0; Y0 = y0; W = w; H = h; COLOR = col; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; X0 = 8'hAA; Y0 = 8'h05; W = 9'd7; H = 8'd7; COLOR = 4'hF;
    chk("setup_busy", BUSY, 1);
    chk("setup_we", WE, 0);
    chk("setup_done", DONE, 0);
  endtask

  // Walk exp_q one write per cycle, optionally stalling WACK or poking START mid-fill.
  task automatic run_seq(input logic [3:0] col, input int stall_at, input int stall_n,
                         input int poke_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      if (i == poke_at + 1) START = 1'b0;
      if (i == poke_at) begin START = 1'b1; X0 = 8'd50; end
      if (i == stall_at) begin
        WACK = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_we", WE, 1);
          chk("stall_wa", WA, exp_q[i]);
          chk("stall_wd", WD, col);
          @(negedge CLK);
        end
        WACK = 1'b1;
      end
      chk("we", WE, 1);
      chk("wa", WA, exp_q[i]);
      chk("wd", WD, col);
      chk("done_low", DONE, 0);
    end
    @(negedge CLK);
    START = 1'b0;
    chk("fin_done", DONE, 1);
    chk("fin_we", WE, 0);
    chk("fin_busy", BUSY, 1);
    @(negedge CLK);
    chk("idle_done", DONE, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_we", WE, 0);
  endtask

  task automatic empty_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [8:0] w, input logic [7:0] h);
    launch(x0, y0, w, h, 4'h3);
    @(negedge CLK);
    chk("empty_done", DONE, 1);
    chk("empty_busy", BUSY, 1);
    chk("empty_we", WE, 0);
    @(negedge CLK);
    chk("empty_done_end", DONE, 0);
    chk("empty_busy_end", BUSY, 0);
    chk("empty_we_end", WE, 0);
  endtask

  task automatic load_case1();
    exp_q = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
  endtask

  initial begin
    #1;
    chk("rst_we", WE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_wa", WA, 0);
    chk("rst_wd", WD, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // 1: basic 3x2 fill
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    load_case1();
    run_seq(4'd5, -1, 0, -10);

    // 2: clipped at the bottom-right corner
    launch(8'd254, 8'd238, 9'd4, 8'd5, 4'd9);
    exp_q = '{16'hEEFE, 16'hEEFF, 16'hEFFE, 16'hEFFF};
    run_seq(4'd9, -1, 0, -10);

    // 3: WACK low for three cycles while WA=140B
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    load_case1();
    run_seq(4'd5, 1, 3, -10);

    // 4: empty rectangles
    empty_fill(8'd10, 8'd20, 9'd0, 8'd2);
    empty_fill(8'd10, 8'd240, 9'd3, 8'd2);
    empty_fill(8'd10, 8'd20, 9'd3, 8'd0);

    // 5a: ABORT after two acks, then a fresh fill
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    @(negedge CLK); chk("ab_wa0", WA, 16'h140A);
    @(negedge CLK); chk("ab_wa1", WA, 16'h140B);
    @(negedge CLK); chk("ab_wa2", WA, 16'h140C);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("ab_we", WE, 0);
    chk("ab_busy", BUSY, 0);
    chk("ab_done", DONE, 0);
    @(negedge CLK);
    chk("ab_done_later", DONE, 0);
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    load_case1();
    run_seq(4'd5, -1, 0, -10);

    // 5b: reset mid-fill
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    @(negedge CLK); chk("rs_wa0", WA, 16'h140A);
    @(negedge CLK); chk("rs_wa1", WA, 16'h140B);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("rs_we", WE, 0);
    chk("rs_busy", BUSY, 0);
    chk("rs_done", DONE, 0);
    chk("rs_wa", WA, 0);
    chk("rs_wd", WD, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rs_idle", BUSY, 0);
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    load_case1();
    run_seq(4'd5, -1, 0, -10);

    // 6: START with new X0 during WRITE is ignored
    launch(8'd10, 8'd20, 9'd3, 8'd2, 4'd5);
    load_case1();
    run_seq(4'd5, -1, 0, 2);
    @(negedge CLK);
    chk("poke_no_restart", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
